// File: rtl/dm_store_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_store_queue_if
// Purpose  : Bundles the store-queue handshake and bus signals. These are the
//            MEM-stage store request, the load-hazard probe, the data-memory
//            write port and the occupancy status.
// Modports : master - MEM stage / data-memory side (drives st_*, ld_addr,
//                     drain_en)
//            slave  - the store queue itself
// Params   : DEPTH  - queue entries; sets the width of count
// Revision : 1.0 - initial release
// ============================================================================
interface dm_store_queue_if #(
  parameter int DEPTH = 4
);
  localparam int c_count_w = $clog2(DEPTH) + 1;

  logic                 st_valid;
  logic                 st_ready;
  logic [31:0]          st_addr;
  logic [31:0]          st_data;
  logic [1:0]           st_width;
  logic [31:0]          st_pc;
  logic [31:0]          ld_addr;
  logic                 ld_hazard;
  logic                 drain_en;
  logic                 dm_we;
  logic [31:0]          dm_addr;
  logic [31:0]          dm_wdata;
  logic [1:0]           dm_width;
  logic [31:0]          dm_pc;
  logic [c_count_w-1:0] count;
  logic                 full;
  logic                 empty;

  modport master (
    output st_valid, st_addr, st_data, st_width, st_pc, ld_addr, drain_en,
    input  st_ready, ld_hazard, dm_we, dm_addr, dm_wdata, dm_width, dm_pc,
           count, full, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_width, st_pc, ld_addr, drain_en,
    output st_ready, ld_hazard, dm_we, dm_addr, dm_wdata, dm_width, dm_pc,
           count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/dm_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : dm_store_queue
// Purpose  : In-order store queue between the MEM stage and data memory.
//            Stores are buffered in a circular FIFO and drained one per cycle
//            when drain_en allows. A load in MEM is flagged when any queued
//            store hits the same 32-bit word.
// Ports    : clk   - sole clock, rising edge
//            reset - asynchronous, active-low; clears all state at once
//            bus   - dm_store_queue_if.slave (st_*, ld_*, dm_*, drain_en,
//                    count, full, empty)
// Params   : DEPTH - entries, power of two in 2..16
// Revision : 1.0 - initial release
// ============================================================================
module dm_store_queue #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  dm_store_queue_if.slave bus
);
  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_count_w = c_ptr_w + 1;

  logic [31:0]          r_addr  [DEPTH];
  logic [31:0]          r_data  [DEPTH];
  logic [1:0]           r_width [DEPTH];
  logic [31:0]          r_pc    [DEPTH];
  logic [c_ptr_w-1:0]   r_head;
  logic [c_ptr_w-1:0]   r_tail;
  logic [c_count_w-1:0] r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [DEPTH-1:0]     w_match;
  logic                 w_unused_ld;

  assign w_full  = (r_count == c_count_w'(DEPTH));
  assign w_empty = (r_count == '0);

  // Gated with reset so that st_ready and dm_we are low while reset is held.
  // Without the gate, the cleared count would make st_ready read as 1.
  assign bus.st_ready = reset & ~w_full;
  assign bus.dm_we    = reset & ~w_empty & bus.drain_en;

  assign w_push = bus.st_valid & bus.st_ready;
  assign w_pop  = bus.dm_we;

  assign bus.count = r_count;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;

  assign bus.dm_addr  = w_empty ? 32'd0 : r_addr[r_head];
  assign bus.dm_wdata = w_empty ? 32'd0 : r_data[r_head];
  assign bus.dm_width = w_empty ? 2'd0  : r_width[r_head];
  assign bus.dm_pc    = w_empty ? 32'd0 : r_pc[r_head];

  // Pointers and occupancy. DEPTH is a power of two, so the pointer
  // increment wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload. This storage needs no reset: only slots inside the
  // head..count window are ever observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail]  <= bus.st_addr;
      r_data[r_tail]  <= bus.st_data;
      r_width[r_tail] <= bus.st_width;
      r_pc[r_tail]    <= bus.st_pc;
    end
  end

  // A slot is occupied when its distance from head, modulo DEPTH, is less
  // than count. Only occupied slots take part in the word-address compare.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
      logic [c_ptr_w-1:0] w_off;
      assign w_off = c_ptr_w'(gi) - r_head;
      assign w_match[gi] = ({1'b0, w_off} < r_count) &&
                           (r_addr[gi][13:2] == bus.ld_addr[13:2]);
    end
  endgenerate

  assign bus.ld_hazard = |w_match;

  // Load address bits outside the word index do not affect the hazard.
  assign w_unused_ld = ^{bus.ld_addr[31:14], bus.ld_addr[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_dm_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_store_queue
// Purpose  : Self-checking bench for dm_store_queue. Directed scenarios are
//            followed by randomized traffic. Every cycle, all outputs are
//            compared with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_store_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  ent_t        q[$];
  logic        in_rst;
  logic        exp_push;
  logic        exp_pop;
  logic        cur_valid;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic [1:0]  cur_width;
  logic [31:0] cur_pc;
  logic [31:0] cur_ld;
  logic        cur_drain;

  dm_store_queue_if #(.DEPTH(DEPTH)) bus ();

  dm_store_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the model's occupancy and the current inputs.
  task automatic check_all();
    logic e_ready;
    logic e_we;
    logic e_haz;
    ent_t h;
    e_ready = !in_rst && (q.size() < DEPTH);
    e_we    = !in_rst && (q.size() > 0) && cur_drain;
    h       = '{32'd0, 32'd0, 2'd0, 32'd0};
    if (q.size() > 0) h = q[0];
    e_haz = 1'b0;
    foreach (q[k]) if (q[k].a[13:2] == cur_ld[13:2]) e_haz = 1'b1;
    chk("st_ready",  {31'd0, bus.st_ready},  {31'd0, e_ready});
    chk("dm_we",     {31'd0, bus.dm_we},     {31'd0, e_we});
    chk("dm_addr",   bus.dm_addr,            h.a);
    chk("dm_wdata",  bus.dm_wdata,           h.d);
    chk("dm_width",  {30'd0, bus.dm_width},  {30'd0, h.w});
    chk("dm_pc",     bus.dm_pc,              h.pc);
    chk("ld_hazard", {31'd0, bus.ld_hazard}, {31'd0, e_haz});
    chk("count",     32'(bus.count),         32'(q.size()));
    chk("full",      {31'd0, bus.full},      {31'd0, (q.size() == DEPTH)});
    chk("empty",     {31'd0, bus.empty},     {31'd0, (q.size() == 0)});
    exp_push = cur_valid && e_ready;
    exp_pop  = e_we;
  endtask

  task automatic drive_in();
    bus.st_valid = cur_valid;
    bus.st_addr  = cur_addr;
    bus.st_data  = cur_data;
    bus.st_width = cur_width;
    bus.st_pc    = cur_pc;
    bus.ld_addr  = cur_ld;
    bus.drain_en = cur_drain;
  endtask

  // One clock: drive, check before the edge, clock, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w, input logic [31:0] pc,
                       input logic [31:0] ld, input logic dr);
    cur_valid = v;  cur_addr = a; cur_data = d; cur_width = w;
    cur_pc = pc;    cur_ld = ld;  cur_drain = dr;
    drive_in();
    #1;
    check_all();
    @(posedge clk);
    if (!in_rst) begin
      if (exp_pop)  void'(q.pop_front());
      if (exp_push) q.push_back('{a, d, w, pc});
    end
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    in_rst = 1'b1;
    cur_valid = 1'b0; cur_addr = '0; cur_data = '0; cur_width = '0;
    cur_pc = '0; cur_ld = '0; cur_drain = 1'b1;
    drive_in();
    reset = 1'b0;

    // Reset state, checked with drain enabled and a store offered
    @(posedge clk); #1;
    cycle(1'b1, 32'h40, 32'h1, 2'd0, 32'h4, 32'h40, 1'b1);
    reset  = 1'b1;
    in_rst = 1'b0;

    // Single word store drained on the next cycle
    cycle(1'b1, 32'h10, 32'h11223344, 2'd0, 32'h100, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0, 1'b1);

    // Fill to full, refuse the fifth store, then drain in order
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 2'(i % 3), 32'h200 + 32'(i * 4), 32'h0, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0, 1'b1);

    // Count held at 2 across simultaneous push and pop; pointers wrap
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 32'h300 + 32'(i * 4), 32'hB0 + 32'(i), 2'd1, 32'h400 + 32'(i), 32'h0, 1'b0);
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h310 + 32'(i * 4), 32'hC0 + 32'(i), 2'd2, 32'h500 + 32'(i), 32'h0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h0, 1'b1);

    // Load hazard on the same word, none on the next word, cleared after pop
    cycle(1'b1, 32'h23, 32'hAB, 2'd2, 32'h600, 32'h20, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h20, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h24, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h20, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 32'h20, 1'b0);

    // Asynchronous reset between edges with three entries pending
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h700 + 32'(i * 4), 32'hD0 + 32'(i), 2'd0, 32'h800 + 32'(i), 32'h700, 1'b0);
    cur_drain = 1'b1;
    drive_in();
    reset  = 1'b0;
    in_rst = 1'b1;
    q.delete();
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    reset  = 1'b1;
    in_rst = 1'b0;
    #1;
    check_all();

    // Randomized traffic over a small word range so hazards occur often
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
            2'($urandom_range(0, 2)), $urandom, 32'($urandom_range(0, 63)),
            1'($urandom_range(0, 2) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dm_store_queue.md
DM_STORE_QUEUE -- requirements
Module: dm_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16), store-queue entries.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 SHALL have port st_valid  input  1  MEM stage presents a store.
REQ-005 SHALL have port st_ready  output  1  queue accepts a store this cycle.
REQ-006 SHALL have port st_addr  input  32  store byte address.
REQ-007 SHALL have port st_data  input  32  store data, unshifted; byte in [7:0], half in [15:0].
REQ-008 SHALL have port st_width  input  2  00 word, 01 half, 10 byte; 11 treated as word.
REQ-009 SHALL have port st_pc  input  32  PC of the store instruction.
REQ-010 SHALL have port ld_addr  input  32  address of the load currently in MEM.
REQ-011 SHALL have port ld_hazard  output  1  a queued store targets the load's word.
REQ-012 SHALL have port drain_en  input  1  data memory may take a write this cycle.
REQ-013 SHALL have port dm_we  output  1  write enable to data memory.
REQ-014 SHALL have ports dm_addr 32, dm_wdata 32, dm_width 2, dm_pc 32, all outputs, carrying the head entry's fields.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-016 SHALL have ports full, empty  outputs  1  count==DEPTH, count==0.

Function
REQ-017 SHALL be a circular FIFO of DEPTH entries {addr, data, width, pc}, with head/tail pointers wrapping modulo DEPTH.
REQ-018 SHALL drive st_ready = !full; a full queue does not accept a store, even when a pop occurs in the same cycle.
REQ-019 SHALL push at the rising edge when st_valid && st_ready, writing the entry at tail and advancing tail by 1.
REQ-020 SHALL drive dm_we = !empty && drain_en combinationally, with dm_* equal to the head entry and stable while not popped.
REQ-021 SHALL pop at the rising edge when dm_we is 1, advancing head by 1; the data memory commits the write on the same edge.
REQ-022 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-023 SHALL make a pushed entry visible on dm_* no earlier than the cycle after the push; there is no same-cycle bypass, so minimum latency is 1 cycle.
REQ-024 SHALL drive dm_* as zero when empty.
REQ-025 SHALL drive ld_hazard = 1 iff some occupied entry has addr[13:2] == ld_addr[13:2], compared over occupied entries only, combinationally.
REQ-026 SHALL exclude an entry from ld_hazard once it pops, so ld_hazard drops in the cycle after the edge at which that entry pops.
REQ-027 SHALL NOT merge, reorder or drop stores: DM writes occur in push order, one per popping edge.
REQ-028 SHALL ignore st_* when st_valid==0 and leave state unchanged.

Reset
REQ-029 SHALL, while reset==0, force head=0, tail=0, count=0, empty=1, full=0, st_ready=0, dm_we=0, dm_*=0 and ld_hazard=0, regardless of clk.
REQ-030 SHALL discard all pending entries on a mid-operation reset without issuing any write.
REQ-031 SHALL raise st_ready to 1 on the first cycle after reset deasserts.

Verification
REQ-032 SHALL pass this scenario: after reset, push sw 0x00000010/0x11223344, drain_en=1 -> dm_we=1 next cycle with dm_addr 0x10, dm_wdata 0x11223344, dm_width 00; then empty=1.
REQ-033 SHALL pass this scenario: drain_en=0, push 4 stores -> full=1, st_ready=0, count=4; a 5th st_valid is refused; then drain_en=1 for 4 cycles -> 4 writes in push order, then empty=1.
REQ-034 SHALL pass this scenario: count=2 with simultaneous push and pop -> count stays 2; 6 push/pop cycles -> pointers wrap and order is preserved.
REQ-035 SHALL pass this scenario: queued sb at 0x00000023 with ld_addr 0x00000020 -> ld_hazard=1; ld_addr 0x00000024 -> ld_hazard=0; after that entry pops -> ld_hazard=0.
REQ-036 SHALL pass this scenario: count=3, reset pulsed low between clock edges -> count=0 and dm_we=0 immediately; no further DM writes occur.
